// File: rtl/matmul_stream_sequencer.sv
// Purpose: Wishbone master that runs one complete matmul job on the accelerator slave (config, A, B, go, poll, C readout).
// Latency: at least 3 cycles per bus transaction (stb, ack, gap) plus slave compute time while polling in GO_RD.
// Backpressure: in_ready only when no write is in flight; each C read waits for the previous element's out handshake.
module matmul_stream_sequencer #(
   parameter int MAX_DIM = 15,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 65535
) (
   input  logic              wishbone_clk_i,
   input  logic              wishbone_rst_i,
   input  logic              cfg_start,
   input  logic [3:0]        cfg_rows_a,
   input  logic [3:0]        cfg_cols_a,
   input  logic [3:0]        cfg_cols_b,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [31:0]       wbm_addr_o,
   output logic              wbm_we_o,
   output logic [DATA_W-1:0] wbm_data_o,
   output logic              wbm_stb_o,
   input  logic              wbm_ack_i,
   input  logic [DATA_W-1:0] wbm_data_i,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [3:0] {
      S_IDLE, S_CFG_WR, S_A_WR, S_B_WR, S_GO_WR, S_GO_RD, S_C_RD, S_C_OUT, S_DONE, S_ERR
   } state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic              rst_meta_q, rst_q;
   state_t            state_q, state_d;
   logic [3:0]        rows_a_q, rows_a_d, cols_a_q, cols_a_d, cols_b_q, cols_b_d;
   logic [3:0]        row_q, row_d, col_q, col_d;
   logic [2:0]        idx_q, idx_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              stb_q, stb_d, we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdat_q, wdat_d, odat_q, odat_d;
   logic              olast_q, olast_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic              ack, col_end, last_elem, dims_bad;
   logic [3:0]        lim_r, lim_c;
   logic [DATA_W-1:0] op_val;

   // Reset asserts immediately but releases two clocks later, in step with the clock
   always_ff @(posedge wishbone_clk_i or posedge wishbone_rst_i) begin
      if (wishbone_rst_i) begin
         rst_meta_q <= 1'b1;
         rst_q      <= 1'b1;
      end else begin
         rst_meta_q <= 1'b0;
         rst_q      <= rst_meta_q;
      end
   end

   // Matrix extent walked by the row/col counters in the current phase, plus config register values
   always_comb begin
      lim_r = rows_a_q;
      lim_c = cols_a_q;
      if (state_q == S_B_WR) begin
         lim_r = cols_a_q;
         lim_c = cols_b_q;
      end else if (state_q == S_C_RD || state_q == S_C_OUT) begin
         lim_c = cols_b_q;
      end
      col_end   = (col_q == lim_c - 4'd1);
      last_elem = col_end && (row_q == lim_r - 4'd1);
      ack       = stb_q && wbm_ack_i;
      dims_bad  = (cfg_rows_a == 4'd0) || (cfg_cols_a == 4'd0) || (cfg_cols_b == 4'd0) ||
                  (int'(cfg_rows_a) > MAX_DIM) || (int'(cfg_cols_a) > MAX_DIM) ||
                  (int'(cfg_cols_b) > MAX_DIM);
      case (idx_q)
         3'd0:    op_val = DATA_W'(1);
         3'd1:    op_val = DATA_W'(cols_a_q);
         3'd2:    op_val = DATA_W'(rows_a_q);
         3'd3:    op_val = DATA_W'(cols_b_q);
         3'd4:    op_val = DATA_W'(cols_a_q);
         default: op_val = '0;
      endcase
   end

   // Job sequencer: next state, bus transaction control, counters and registered outputs
   always_comb begin
      state_d  = state_q;
      rows_a_d = rows_a_q;
      cols_a_d = cols_a_q;
      cols_b_d = cols_b_q;
      row_d    = row_q;
      col_d    = col_q;
      idx_d    = idx_q;
      stb_d    = stb_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdat_d   = wdat_q;
      odat_d   = odat_q;
      olast_d  = olast_q;
      err_d    = err_q;
      tmo_d    = '0;

      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               rows_a_d = cfg_rows_a;
               cols_a_d = cfg_cols_a;
               cols_b_d = cfg_cols_b;
               row_d    = '0;
               col_d    = '0;
               idx_d    = '0;
               err_d    = dims_bad;
               state_d  = dims_bad ? S_ERR : S_CFG_WR;
            end
         end
         S_CFG_WR: begin
            if (!stb_q) begin
               stb_d  = 1'b1;
               we_d   = 1'b1;
               addr_d = {29'd0, idx_q};
               wdat_d = op_val;
            end else if (ack) begin
               stb_d = 1'b0;
               if (idx_q == 3'd4) begin
                  idx_d   = '0;
                  state_d = S_A_WR;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_A_WR, S_B_WR: begin
            if (!stb_q) begin
               if (in_valid) begin
                  stb_d  = 1'b1;
                  we_d   = 1'b1;
                  wdat_d = in_data;
                  addr_d = {(state_q == S_A_WR) ? 2'b01 : 2'b10, 11'd0, row_q, 11'd0, col_q};
               end
            end else if (ack) begin
               stb_d = 1'b0;
               if (last_elem) begin
                  row_d   = '0;
                  col_d   = '0;
                  state_d = (state_q == S_A_WR) ? S_B_WR : S_GO_WR;
               end else if (col_end) begin
                  col_d = '0;
                  row_d = row_q + 4'd1;
               end else begin
                  col_d = col_q + 4'd1;
               end
            end
         end
         S_GO_WR: begin
            if (!stb_q) begin
               stb_d  = 1'b1;
               we_d   = 1'b1;
               addr_d = 32'd5;
               wdat_d = '1;
            end else if (ack) begin
               stb_d   = 1'b0;
               state_d = S_GO_RD;
            end
         end
         S_GO_RD: begin
            // The slave holds off this ack until the multiplication has finished
            if (!stb_q) begin
               stb_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = 32'd0;
            end else if (ack) begin
               stb_d   = 1'b0;
               row_d   = '0;
               col_d   = '0;
               state_d = S_C_RD;
            end
         end
         S_C_RD: begin
            if (!stb_q) begin
               stb_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = {2'b11, 11'd0, row_q, 11'd0, col_q};
            end else if (ack) begin
               stb_d   = 1'b0;
               odat_d  = wbm_data_i;
               olast_d = last_elem;
               state_d = S_C_OUT;
            end
         end
         S_C_OUT: begin
            if (out_ready) begin
               olast_d = 1'b0;
               if (olast_q) begin
                  row_d   = '0;
                  col_d   = '0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_C_RD;
                  if (col_end) begin
                     col_d = '0;
                     row_d = row_q + 4'd1;
                  end else begin
                     col_d = col_q + 4'd1;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A transaction left unacknowledged for TIMEOUT cycles abandons the job
      if (stb_q && !wbm_ack_i) begin
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            stb_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_ERR;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      done_d = (state_d == S_DONE);
      busy_d = !(state_d == S_IDLE || state_d == S_ERR || state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge wishbone_clk_i or posedge rst_q) begin
      if (rst_q) begin
         state_q  <= S_IDLE;
         rows_a_q <= '0;
         cols_a_q <= '0;
         cols_b_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         idx_q    <= '0;
         tmo_q    <= '0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdat_q   <= '0;
         odat_q   <= '0;
         olast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rows_a_q <= rows_a_d;
         cols_a_q <= cols_a_d;
         cols_b_q <= cols_b_d;
         row_q    <= row_d;
         col_q    <= col_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         stb_q    <= stb_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdat_q   <= wdat_d;
         odat_q   <= odat_d;
         olast_q  <= olast_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign in_ready   = (state_q == S_A_WR || state_q == S_B_WR) && !stb_q;
   assign out_valid  = (state_q == S_C_OUT);
   assign out_data   = odat_q;
   assign out_last   = olast_q;
   assign wbm_addr_o = addr_q;
   assign wbm_we_o   = we_q;
   assign wbm_data_o = wdat_q;
   assign wbm_stb_o  = stb_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = err_q;

endmodule

// File: tb/tb_matmul_stream_sequencer.sv
// Bench for matmul_stream_sequencer: Wishbone slave model with a small matmul memory,
// directed jobs with hand-computed results, bus protocol monitor.
module tb_matmul_stream_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_start = 1'b0;
   logic [3:0]  rows_a = 4'd0, cols_a = 4'd0, cols_b = 4'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdat;
   logic        stb;
   logic        ack;
   logic [31:0] rdata;
   logic        busy, done, error;

   always #5 clk = ~clk;

   matmul_stream_sequencer #(.MAX_DIM(15), .DATA_W(32), .TIMEOUT(100)) dut (
      .wishbone_clk_i(clk), .wishbone_rst_i(rst), .cfg_start(cfg_start),
      .cfg_rows_a(rows_a), .cfg_cols_a(cols_a), .cfg_cols_b(cols_b),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .wbm_addr_o(addr), .wbm_we_o(we), .wbm_data_o(wdat), .wbm_stb_o(stb),
      .wbm_ack_i(ack), .wbm_data_i(rdata), .busy(busy), .done(done), .error(error)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- slave model ----------------
   logic [31:0] a_m [0:15][0:15];
   logic [31:0] b_m [0:15][0:15];
   logic [3:0]  sl_k = 4'd0;
   int          go_delay = 20;
   int          go_cnt;
   logic [31:0] wr_addr [$];
   logic [31:0] wr_dat  [$];

   function automatic logic [31:0] c_val(input logic [3:0] r, input logic [3:0] c);
      logic [31:0] s = 32'd0;
      for (int k = 0; k < int'(sl_k); k++) s += a_m[r][k] * b_m[k][c];
      return s;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack    <= 1'b0;
         rdata  <= 32'd0;
         go_cnt <= 0;
      end else begin
         ack <= 1'b0;
         if (stb && !ack) begin
            if (we) begin
               ack <= 1'b1;
               wr_addr.push_back(addr);
               wr_dat.push_back(wdat);
               if (addr == 32'd1) sl_k <= wdat[3:0];
               if (addr[31:30] == 2'b01) a_m[addr[18:15]][addr[3:0]] <= wdat;
               if (addr[31:30] == 2'b10) b_m[addr[18:15]][addr[3:0]] <= wdat;
            end else if (addr == 32'd0) begin
               if (go_cnt >= go_delay) begin
                  ack    <= 1'b1;
                  rdata  <= 32'd0;
                  go_cnt <= 0;
               end else begin
                  go_cnt <= go_cnt + 1;
               end
            end else begin
               ack   <= 1'b1;
               rdata <= c_val(addr[18:15], addr[3:0]);
            end
         end else if (!stb) begin
            go_cnt <= 0;
         end
      end
   end

   // ---------------- monitors (sampled on the falling edge) ----------------
   logic [31:0] out_q [$];
   logic        last_q [$];
   int          in_hs = 0, done_cnt = 0, stb_cyc = 0, run = 0, last_run = 0, viol = 0;
   logic        p_ack = 1'b0, p_stb = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = 32'd0, p_wdat = 32'd0;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         out_q.push_back(out_data);
         last_q.push_back(out_last);
      end
      if (in_valid && in_ready) in_hs++;
      if (done) done_cnt++;
      if (stb) begin
         stb_cyc++;
         run++;
      end else begin
         if (run > 0) last_run = run;
         run = 0;
      end
      if (stb && p_ack) viol++;
      if (stb && p_stb && !p_ack && (addr != p_addr || we != p_we || wdat != p_wdat)) viol++;
      p_ack = ack; p_stb = stb; p_we = we; p_addr = addr; p_wdat = wdat;
   end

   function automatic logic [31:0] out_at(input int i);
      if (i < out_q.size()) return out_q[i];
      return 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] last_at(input int i);
      if (i < last_q.size()) return {31'd0, last_q[i]};
      return 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] wa_at(input int i);
      if (i < wr_addr.size()) return wr_addr[i];
      return 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] wd_at(input int i);
      if (i < wr_dat.size()) return wr_dat[i];
      return 32'hDEAD_BEEF;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [3:0] r, input logic [3:0] k, input logic [3:0] c);
      @(posedge clk); #1;
      rows_a = r; cols_a = k; cols_b = c; cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d);
      bit ok = 0;
      int i = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!ok && i < 300) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         i++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!ok) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_end(input string tag, input int bound);
      bit seen = 0;
      int i = 0;
      while (!seen && i < bound) begin
         @(negedge clk);
         if (done || error) seen = 1;
         i++;
      end
      if (!seen) check(tag, 32'd0, 32'd1);
      tick(2);
   endtask

   logic [31:0] t2_addr [14] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4,
                                 32'h4000_0000, 32'h4000_0001, 32'h4000_8000, 32'h4000_8001,
                                 32'h8000_0000, 32'h8000_0001, 32'h8000_8000, 32'h8000_8001, 32'h5};
   logic [31:0] t2_dat  [14] = '{32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd1, 32'd0, 32'd0, 32'd1,
                                 32'd5, 32'd6, 32'd7, 32'd8, 32'hFFFF_FFFF};
   logic [31:0] t2_out  [4]  = '{32'd5, 32'd6, 32'd7, 32'd8};
   logic [31:0] t6_out  [4]  = '{32'd19, 32'd22, 32'd43, 32'd50};
   logic [31:0] b_in    [6]  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};

   initial begin
      int ob, wb, db, sb, hb, nb;

      // ---- reset state ----
      tick(3);
      check("rst_stb", {31'd0, stb}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick(4);
      check("idle_stb", {31'd0, stb}, 32'd0);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_error", {31'd0, error}, 32'd0);

      // ---- job 1: 2x2x2 identity times B, with an input gap ----
      ob = out_q.size(); wb = wr_addr.size(); db = done_cnt;
      start_job(4'd2, 4'd2, 4'd2);
      check("t2_busy", {31'd0, busy}, 32'd1);
      send(32'd1);
      send(32'd0);
      tick(6);
      check("t2_gap_stb", {31'd0, stb}, 32'd0);
      check("t2_gap_in_ready", {31'd0, in_ready}, 32'd1);
      check("t2_gap_writes", 32'(wr_addr.size() - wb), 32'd7);
      send(32'd0);
      send(32'd1);
      for (int i = 0; i < 4; i++) send(t2_out[i]);
      wait_end("t2_end_timeout", 600);
      check("t2_nwrites", 32'(wr_addr.size() - wb), 32'd14);
      for (int i = 0; i < 14; i++) begin
         check($sformatf("t2_waddr%0d", i), wa_at(wb + i), t2_addr[i]);
         check($sformatf("t2_wdat%0d", i), wd_at(wb + i), t2_dat[i]);
      end
      check("t2_nout", 32'(out_q.size() - ob), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_out%0d", i), out_at(ob + i), t2_out[i]);
         check($sformatf("t2_last%0d", i), last_at(ob + i), (i == 3) ? 32'd1 : 32'd0);
      end
      check("t2_done", 32'(done_cnt - db), 32'd1);
      check("t2_error", {31'd0, error}, 32'd0);
      check("t2_busy_end", {31'd0, busy}, 32'd0);

      // ---- job 2: 1x3x2 with output stall and surplus input ----
      ob = out_q.size(); wb = wr_addr.size(); db = done_cnt; hb = in_hs;
      out_ready = 1'b0;
      start_job(4'd1, 4'd3, 4'd2);
      send(32'd1); send(32'd2); send(32'd3);
      for (int i = 0; i < 6; i++) send(b_in[i]);
      in_valid = 1'b1;
      in_data  = 32'h99;
      begin
         int i = 0;
         while (!out_valid && i < 300) begin
            @(negedge clk);
            i++;
         end
      end
      check("t3_first_valid", {31'd0, out_valid}, 32'd1);
      sb = stb_cyc;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_stall_data", out_data, 32'd22);
      end
      check("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      check("t3_stall_no_read", 32'(stb_cyc - sb), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_end("t3_end_timeout", 600);
      in_valid = 1'b0;
      nb = 0;
      for (int i = wb; i < wr_addr.size(); i++) if (wr_addr[i][31:30] == 2'b10) nb++;
      check("t3_b_writes", 32'(nb), 32'd6);
      check("t3_in_beats", 32'(in_hs - hb), 32'd9);
      check("t3_out0", out_at(ob), 32'd22);
      check("t3_out1", out_at(ob + 1), 32'd28);
      check("t3_last0", last_at(ob), 32'd0);
      check("t3_last1", last_at(ob + 1), 32'd1);
      check("t3_done", 32'(done_cnt - db), 32'd1);

      // ---- bad dimension ----
      sb = stb_cyc; db = done_cnt;
      start_job(4'd2, 4'd0, 4'd2);
      tick(1);
      check("t4_error", {31'd0, error}, 32'd1);
      check("t4_busy", {31'd0, busy}, 32'd0);
      tick(3);
      check("t4_error_sticky", {31'd0, error}, 32'd1);
      check("t4_no_stb", 32'(stb_cyc - sb), 32'd0);
      check("t4_no_done", 32'(done_cnt - db), 32'd0);

      // ---- GO_RD never acked: timeout ----
      go_delay = 100000;
      db = done_cnt;
      start_job(4'd1, 4'd1, 4'd1);
      check("t5_error_cleared", {31'd0, error}, 32'd0);
      send(32'd3);
      send(32'd4);
      wait_end("t5_end_timeout", 600);
      check("t5_error", {31'd0, error}, 32'd1);
      check("t5_stb_run", 32'(last_run), 32'd100);
      check("t5_stb_low", {31'd0, stb}, 32'd0);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_no_done", 32'(done_cnt - db), 32'd0);
      go_delay = 20;

      // ---- reset during B writes, then a fresh job ----
      start_job(4'd2, 4'd2, 4'd2);
      check("t6_error_cleared", {31'd0, error}, 32'd0);
      for (int i = 0; i < 5; i++) send(b_in[i]);
      check("t6_pre_stb", {31'd0, stb}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_stb", {31'd0, stb}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
      tick(3);
      rst = 1'b0;
      tick(4);
      ob = out_q.size(); db = done_cnt;
      start_job(4'd2, 4'd2, 4'd2);
      for (int i = 0; i < 4; i++) send(32'(i + 1));
      for (int i = 0; i < 4; i++) send(32'(i + 5));
      wait_end("t6_end_timeout", 600);
      check("t6_nout", 32'(out_q.size() - ob), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t6_out%0d", i), out_at(ob + i), t6_out[i]);
         check($sformatf("t6_last%0d", i), last_at(ob + i), (i == 3) ? 32'd1 : 32'd0);
      end
      check("t6_done", 32'(done_cnt - db), 32'd1);
      check("t6_error", {31'd0, error}, 32'd0);

      check("bus_protocol_violations", 32'(viol), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
